// File: rtl/bus_mem.sv
// Bus-side memory and I/O slave for the 8-bit CPU.
// 254-byte RAM, one input port, one output port, programmable wait states.
module bus_mem #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       read,
  input  logic       write,
  output logic       ready,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  localparam logic [7:0] RAM_TOP = 8'hFD;
  localparam logic [7:0] GPI_ADR = 8'hFE;
  localparam logic [7:0] GPO_ADR = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       is_wr_q, is_wr_d;
  logic       ready_q, ready_d;
  logic [7:0] gpo_q, gpo_d;
  logic [7:0] dout_q;
  logic       commit;

  logic [7:0] ram_q [0:253];
  logic       ram_we;
  logic [7:0] ram_wa;
  logic [7:0] ram_wd;
  logic       ld_ok;
  logic       bus_ram_wr;

  assign data_out = dout_q;
  assign ready    = ready_q;
  assign gpio_out = gpo_q;

  // Handshake FSM: latch request, count wait states, commit, hold ACK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    ready_d = ready_q;
    gpo_d   = gpo_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (read || write) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          addr_d  = address;
          wdata_d = data_in;
          is_wr_d = write;
        end
      end
      S_WAIT: begin
        if (!load_en) begin
          if (cnt_q == WC) begin
            commit  = 1'b1;
            state_d = S_ACK;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (!read && !write) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit && is_wr_q && addr_q == GPO_ADR)
      gpo_d = wdata_q;
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      ready_q <= 1'b0;
      gpo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      ready_q <= ready_d;
      gpo_q   <= gpo_d;
    end
  end

  // Read data register; loads only when a read commits
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else if (commit && !is_wr_q) begin
      if (addr_q == GPI_ADR)
        dout_q <= gpio_in;
      else if (addr_q == GPO_ADR)
        dout_q <= gpo_q;
      else
        dout_q <= ram_q[addr_q];
    end
  end

  // Write port mux: load port wins (bus never commits while loading)
  assign ld_ok      = load_en && (load_addr <= RAM_TOP);
  assign bus_ram_wr = commit && is_wr_q && (addr_q <= RAM_TOP);
  assign ram_we     = ld_ok || bus_ram_wr;
  assign ram_wa     = ld_ok ? load_addr : addr_q;
  assign ram_wd     = ld_ok ? load_data : wdata_q;

  // Single write port RAM; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we)
      ram_q[ram_wa] <= ram_wd;
  end

endmodule

// File: tb/tb_bus_mem.sv
// Randomized scoreboard bench for bus_mem.
// Expected responses queued at issue, checked by a monitor on ready.
module tb_bus_mem;

  localparam int W = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic       ready;
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;

  bus_mem #(.WAIT_CYCLES(W)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .data_in(data_in),
    .data_out(data_out),
    .read(read),
    .write(write),
    .ready(ready),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] dout;
    logic [7:0] gpo;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [256];
  bit         mval [256];
  logic [7:0] m_dout;
  logic [7:0] m_gpo;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every rising ready is one completed access
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ready === 1'b1 && prev_rdy !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("data_out", int'(data_out), int'(e.dout));
        chk("gpio_out", int'(gpio_out), int'(e.gpo));
        chk("latency", cyc, e.cyc);
      end
    end
    prev_rdy = ready;
  end

  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    if (a <= 8'hFD) begin
      mdl[a] = d;
      mval[a] = 1'b1;
    end
  endtask

  task automatic access(input bit rd, input bit wr,
                        input logic [7:0] a, input logic [7:0] d,
                        input int stall,
                        input logic [7:0] la, input logic [7:0] ld);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    read = rd;
    write = wr;
    address = a;
    data_in = d;
    n = cyc + 1;
    if (stall > 0 && la <= 8'hFD) begin
      mdl[la] = ld;
      mval[la] = 1'b1;
    end
    if (wr) begin
      if (a <= 8'hFD) begin
        mdl[a] = d;
        mval[a] = 1'b1;
      end else if (a == 8'hFF) begin
        m_gpo = d;
      end
    end else if (a == 8'hFE) begin
      m_dout = gpio_in;
    end else if (a == 8'hFF) begin
      m_dout = m_gpo;
    end else begin
      m_dout = mdl[a];
    end
    e.dout = m_dout;
    e.gpo = m_gpo;
    e.cyc = n + 1 + W + stall;
    sb.push_back(e);
    @(negedge clk);
    address = 8'($urandom);
    data_in = 8'($urandom);
    for (int k = 0; k < stall; k++) begin
      load_en = 1'b1;
      load_addr = la;
      load_data = ld;
      @(negedge clk);
    end
    load_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ready === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ready_timeout got 0 expected 1");
    end
    @(negedge clk);
    chk("ack_hold", int'(ready), 1);
    read = 1'b0;
    write = 1'b0;
    @(negedge clk);
    chk("ack_drop", int'(ready), 0);
  endtask

  initial begin
    reset = 1'b1;
    address = 8'hA5;
    data_in = 8'h5A;
    read = 1'b1;
    write = 1'b1;
    load_en = 1'b0;
    load_addr = 8'hFF;
    load_data = 8'h00;
    gpio_in = 8'hE7;
    for (int i = 0; i < 256; i++) mval[i] = 1'b0;
    m_dout = 8'h00;
    m_gpo = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_dout", int'(data_out), 0);
    chk("rst_gpo", int'(gpio_out), 0);
    read = 1'b0;
    write = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", int'(ready), 0);

    do_load(8'h10, 8'h5A);
    access(1, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00);
    access(0, 1, 8'h20, 8'hC3, 0, 8'h00, 8'h00);
    access(1, 0, 8'h20, 8'h00, 0, 8'h00, 8'h00);
    access(0, 1, 8'hFF, 8'h81, 0, 8'h00, 8'h00);
    access(1, 0, 8'hFF, 8'h00, 0, 8'h00, 8'h00);
    gpio_in = 8'h3C;
    access(1, 0, 8'hFE, 8'h00, 0, 8'h00, 8'h00);
    access(1, 1, 8'h30, 8'h77, 0, 8'h00, 8'h00);
    access(1, 0, 8'h30, 8'h00, 0, 8'h00, 8'h00);
    access(0, 1, 8'hFE, 8'h12, 0, 8'h00, 8'h00);

    do_load(8'h40, 8'h11);
    @(negedge clk);
    write = 1'b1;
    address = 8'h40;
    data_in = 8'h99;
    @(negedge clk);
    reset = 1'b1;
    write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_dout = 8'h00;
    m_gpo = 8'h00;
    chk("abort_dout", int'(data_out), 0);
    chk("abort_gpo", int'(gpio_out), 0);
    repeat (6) @(negedge clk);
    chk("abort_noready", int'(ready), 0);
    access(1, 0, 8'h40, 8'h00, 0, 8'h00, 8'h00);

    access(0, 1, 8'hFF, 8'h6E, 0, 8'h00, 8'h00);
    access(1, 0, 8'h10, 8'h00, 3, 8'hFF, 8'hAA);
    access(1, 0, 8'h50, 8'h00, 3, 8'h50, 8'hB4);

    for (int t = 0; t < 60; t++) begin
      int          op;
      int          st;
      logic [7:0]  a;
      logic [7:0]  d;
      logic [7:0]  la;
      op = int'($urandom_range(0, 4));
      st = int'($urandom_range(0, 2));
      a = 8'($urandom);
      d = 8'($urandom);
      la = 8'($urandom);
      gpio_in = 8'($urandom);
      if (op == 0) begin
        do_load(la, d);
      end else if (op == 1) begin
        access(0, 1, a, d, st, la, 8'($urandom));
      end else if (op == 2) begin
        access(1, 1, a, d, st, la, 8'($urandom));
      end else begin
        if (a <= 8'hFD && !mval[a]) a = 8'hFE;
        access(1, 0, a, d, st, la, 8'($urandom));
      end
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
